// File: rtl/siso_pkg.sv
// rtl/siso_pkg.sv - shared state encodings, line levels and frame length helper
package siso_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

  function automatic int frame_len(input int data_w, input int parity_en);
    return 2 + data_w + parity_en;
  endfunction

endpackage

// File: rtl/siso_frame_tx.sv
// rtl/siso_frame_tx.sv - parallel-in framed serial-out transmitter feeding the 4-bit SISO shifter
module siso_frame_tx
  import siso_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sdo,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt, shreg_shifted;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              par_q, par_nxt;
  logic              sdo_nxt;
  logic              xfer;
  logic              out_bit;

  assign din_ready  = (state == IDLE) || (state == STOP);
  assign xfer       = din_valid && din_ready;
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP);

  // The next data bit always sits at the outgoing end of the shift register.
  assign out_bit       = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];
  assign shreg_shifted = MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0} : {1'b0, shreg[DATA_W-1:1]};

  // sdo is registered, so each branch selects the level for the state being entered.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    par_nxt   = par_q;
    sdo_nxt   = IDLE_LEVEL;
    case (state)
      IDLE, STOP: begin
        if (xfer) begin
          state_nxt = START;
          shreg_nxt = din;
          par_nxt   = ^din;
          sdo_nxt   = START_BIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        state_nxt = DATA;
        cnt_nxt   = '0;
        sdo_nxt   = out_bit;
        shreg_nxt = shreg_shifted;
      end
      DATA: begin
        if (cnt == LAST_BIT) begin
          if (PARITY_EN) begin
            state_nxt = PARITY;
            sdo_nxt   = par_q;
          end else begin
            state_nxt = STOP;
            sdo_nxt   = STOP_BIT;
          end
        end else begin
          cnt_nxt   = cnt + 1'b1;
          sdo_nxt   = out_bit;
          shreg_nxt = shreg_shifted;
        end
      end
      PARITY: begin
        state_nxt = STOP;
        sdo_nxt   = STOP_BIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      par_q <= 1'b0;
      sdo   <= IDLE_LEVEL;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      par_q <= par_nxt;
      sdo   <= sdo_nxt;
    end
  end

endmodule

// File: tb/tb_siso_frame_tx.sv
// tb/tb_siso_frame_tx.sv - scoreboard bench for siso_frame_tx (MSB-first+parity and LSB-first no-parity instances)
module tb_siso_frame_tx;

  typedef logic [1:0] ent_t; // {sdo, frame_done}

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din_a = 8'h00, din_b = 8'h00;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, ready_b, sdo_a, sdo_b, busy_a, busy_b, fd_a, fd_b;
  logic [3:0] sr;
  logic [3:0] hist = 4'b0000;
  ent_t       q_a[$];
  ent_t       q_b[$];
  int         passed = 0;
  int         total = 0;

  always #5 clk = ~clk;

  siso_frame_tx #(.DATA_W(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .sdo(sdo_a), .busy(busy_a), .frame_done(fd_a)
  );

  siso_frame_tx #(.DATA_W(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .sdo(sdo_b), .busy(busy_b), .frame_done(fd_b)
  );

  // Downstream 4-bit SISO shift register model driven by dut_a.
  always @(posedge clk) sr <= reset ? 4'b0000 : {sr[2:0], sdo_a};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_frame(input int which, input logic [7:0] w);
    ent_t f[$];
    f.push_back(2'b10);
    if (which == 0) begin
      for (int i = 7; i >= 0; i--) f.push_back({w[i], 1'b0});
      f.push_back({^w, 1'b0});
    end else begin
      for (int i = 0; i < 8; i++) f.push_back({w[i], 1'b0});
    end
    f.push_back(2'b01);
    foreach (f[i]) begin
      if (which == 0) q_a.push_back(f[i]);
      else q_b.push_back(f[i]);
    end
  endtask

  task automatic send(input int which, input logic [7:0] w, input bit keep);
    int n = 0;
    if (which == 0) begin din_a = w; valid_a = 1'b1; end
    else begin din_b = w; valid_b = 1'b1; end
    @(negedge clk);
    while (!(which == 0 ? ready_a : ready_b) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", (which == 0 ? ready_a : ready_b), 1);
    @(posedge clk);
    #1;
    push_frame(which, w);
    if (!keep) begin
      if (which == 0) valid_a = 1'b0;
      else valid_b = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy_a || busy_b) && n < 200);
    chk("idle_timeout", (n < 200), 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected entry per busy cycle, checks idle line otherwise.
  initial begin
    ent_t ea, eb;
    logic cur_exp;
    forever begin
      @(negedge clk);
      if (reset) begin
        hist = 4'b0000;
      end else begin
        cur_exp = 1'b0;
        if (busy_a) begin
          if (q_a.size() == 0) chk("a_unexpected_frame", busy_a, 0);
          else begin
            ea = q_a.pop_front();
            chk("a_sdo", sdo_a, ea[1]);
            chk("a_frame_done", fd_a, ea[0]);
            cur_exp = ea[1];
          end
        end else begin
          chk("a_idle_line", {sdo_a, fd_a}, 0);
          chk("a_idle_pending", q_a.size(), 0);
        end
        chk("siso_out", sr[3], hist[3]);
        hist = {hist[2:0], cur_exp};
        if (busy_b) begin
          if (q_b.size() == 0) chk("b_unexpected_frame", busy_b, 0);
          else begin
            eb = q_b.pop_front();
            chk("b_sdo", sdo_b, eb[1]);
            chk("b_frame_done", fd_b, eb[0]);
          end
        end else begin
          chk("b_idle_line", {sdo_b, fd_b}, 0);
          chk("b_idle_pending", q_b.size(), 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_a_state", {sdo_a, busy_a, fd_a, ready_a}, 4'b0001);
    chk("rst_b_state", {sdo_b, busy_b, fd_b, ready_b}, 4'b0001);
    @(posedge clk);
    #1;

    // Single frame 8'hA5, din_ready low from START through PARITY.
    send(0, 8'hA5, 1'b0);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (ready_a) break;
      n++;
    end
    chk("t1_ready_low_cycles", n, 10);
    wait_idle();

    // Back-to-back 8'hFF then 8'h00.
    send(0, 8'hFF, 1'b1);
    send(0, 8'h00, 1'b0);
    wait_idle();

    // Odd-weight word, also checked through the SISO model.
    send(0, 8'h07, 1'b0);
    wait_idle();
    repeat (5) @(posedge clk);
    #1;

    // Reset during the third data bit.
    send(0, 8'h96, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    q_a.delete();
    @(posedge clk);
    #1;
    chk("t5_sdo_after_reset", sdo_a, 0);
    chk("t5_busy_after_reset", busy_a, 0);
    chk("t5_ready_after_reset", ready_a, 1);
    reset = 1'b0;
    send(0, 8'h3C, 1'b0);
    wait_idle();

    // Input activity during DATA must be ignored.
    send(0, 8'hC3, 1'b0);
    @(posedge clk);
    #1;
    din_a = 8'h3C;
    valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    din_a = 8'hFF;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;

    // LSB-first, no parity, 10-cycle frame.
    send(1, 8'h01, 1'b0);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (!busy_b) break;
      n++;
    end
    chk("t3_frame_len", n, 10);
    repeat (6) @(posedge clk);
    #1;
    chk("final_q_a_empty", q_a.size(), 0);
    chk("final_q_b_empty", q_b.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
